// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lsu : memory-stage load/store unit, one outstanding access,       |
// |           req/gnt/rvalid data-memory handshake, load align/extend.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+

package mem_lsu_pkg;
  localparam int LSU_XLEN = 64;

  typedef struct packed {
    logic                is_valid;
    logic                mem_rd;
    logic                mem_wr;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic [LSU_XLEN-1:0] mem_addr;
    logic [LSU_XLEN-1:0] mem_data;
    logic [LSU_XLEN-1:0] rf_wr_data;
  } interconnection_struct;
endpackage

module mem_lsu
  import mem_lsu_pkg::interconnection_struct;
#(
  parameter int XLEN = mem_lsu_pkg::LSU_XLEN,
  parameter int BE_W = XLEN/8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  interconnection_struct i_struct,
  output logic                 o_ready,
  output interconnection_struct o_struct,
  output logic                 o_valid,
  input  logic                 i_wb_ready,
  output logic                 o_misaligned,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [BE_W-1:0]      dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_t;

  state_t            r_state;
  logic              w_accept;
  logic              w_is_mem;
  logic              w_misaligned;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_load;

  assign o_ready  = (r_state == ST_IDLE) && (!o_valid || i_wb_ready);
  assign w_accept = i_struct.is_valid && o_ready;
  assign w_is_mem = i_struct.mem_rd || i_struct.mem_wr;

  always_comb begin
    w_misaligned = 1'b0;
    w_wdata      = i_struct.mem_data;
    case (i_struct.mem_size)
      2'd0: begin
        w_misaligned = 1'b0;
        w_wdata      = {(XLEN/8){i_struct.mem_data[7:0]}};
      end
      2'd1: begin
        w_misaligned = i_struct.mem_addr[0];
        w_wdata      = {(XLEN/16){i_struct.mem_data[15:0]}};
      end
      2'd2: begin
        w_misaligned = |i_struct.mem_addr[1:0];
        w_wdata      = {(XLEN/32){i_struct.mem_data[31:0]}};
      end
      default: begin
        w_misaligned = |i_struct.mem_addr[2:0];
        w_wdata      = i_struct.mem_data;
      end
    endcase
  end

  // Only aligned accesses reach memory, so the shifted mask never overflows.
  assign w_be = BE_W'((32'd1 << (32'd1 << i_struct.mem_size)) - 32'd1) << i_struct.mem_addr[2:0];

  always_comb begin
    w_lane = dmem_rdata >> {o_struct.mem_addr[2:0], 3'b000};
    w_load = w_lane;
    case (o_struct.mem_size)
      2'd0: w_load = o_struct.mem_unsigned ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                                           : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      2'd1: w_load = o_struct.mem_unsigned ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                                           : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      2'd2: w_load = o_struct.mem_unsigned ? {{(XLEN-32){1'b0}}, w_lane[31:0]}
                                           : {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
      default: w_load = w_lane;
    endcase
  end

  // o_struct doubles as the in-flight request holder: it is only loaded when
  // the output register is empty or draining, and o_valid stays low meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      o_struct     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
    end else begin
      if (o_valid && i_wb_ready) begin
        o_valid      <= 1'b0;
        o_misaligned <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            o_struct <= i_struct;
            if (!w_is_mem) begin
              o_valid      <= 1'b1;
              o_misaligned <= 1'b0;
            end else if (w_misaligned) begin
              o_struct.is_valid <= 1'b0;
              o_valid           <= 1'b1;
              o_misaligned      <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= i_struct.mem_wr;
              dmem_addr  <= {i_struct.mem_addr[XLEN-1:3], 3'b000};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              o_valid <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_R;
            end
          end
        end
        ST_WAIT_R: begin
          if (dmem_rvalid) begin
            o_struct.rf_wr_data <= w_load;
            o_valid             <= 1'b1;
            r_state             <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_lsu : directed vector table, corner sequences and randomized   |
// |              transactions against a behavioural model of mem_lsu.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  interconnection_struct in_s = '0;
  interconnection_struct o_struct;
  logic                 o_ready, o_valid, o_misaligned;
  logic                 i_wb_ready = 1'b1;
  logic                 dmem_req, dmem_we;
  logic [63:0]          dmem_addr, dmem_wdata;
  logic [7:0]           dmem_be;
  logic                 dmem_gnt = 1'b0;
  logic                 dmem_rvalid = 1'b0;
  logic [63:0]          dmem_rdata = '0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .i_struct(in_s), .o_ready(o_ready),
    .o_struct(o_struct), .o_valid(o_valid), .i_wb_ready(i_wb_ready),
    .o_misaligned(o_misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr, data, rf_in, rdata;
    int          gd;
    logic        mis;
    logic [7:0]  be;
    logic [63:0] wdata, rf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic m_mis(input logic [1:0] sz, input logic [63:0] a);
    return (a % (64'd1 << sz)) != 64'd0;
  endfunction

  function automatic logic [7:0] m_be(input logic [1:0] sz, input logic [63:0] a);
    int n = 1 << sz;
    int off = int'(a[2:0]);
    logic [7:0] b = '0;
    for (int k = 0; k < 8; k++) if (k >= off && k < off + n) b[k] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [1:0] sz, input logic [63:0] d);
    int n = 1 << sz;
    logic [63:0] w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [63:0] a, input logic [63:0] rd);
    int n = 1 << sz;
    logic [63:0] mask = (n == 8) ? '1 : ((64'd1 << (8*n)) - 64'd1);
    logic [63:0] v = (rd >> (8 * int'(a[2:0]))) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] sz, input logic uns,
                              input logic [63:0] a, d, rfi, rdat, input int gd,
                              input logic mis, input logic [7:0] be,
                              input logic [63:0] wd, rf);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = sz; v.uns = uns; v.addr = a; v.data = d;
    v.rf_in = rfi; v.rdata = rdat; v.gd = gd; v.mis = mis; v.be = be;
    v.wdata = wd; v.rf = rf;
    return v;
  endfunction

  // One complete transaction; expects to start at posedge+1 with the unit idle.
  task automatic run_txn(input vec_t v, input int rvd);
    interconnection_struct s;
    s = '0;
    s.is_valid = 1'b1; s.mem_rd = v.rd; s.mem_wr = v.wr; s.mem_size = v.size;
    s.mem_unsigned = v.uns; s.mem_addr = v.addr; s.mem_data = v.data;
    s.rf_wr_data = v.rf_in;
    chk("ready_at_issue", o_ready, 1'b1);
    in_s = s;
    step();
    in_s = '0;
    if (!(v.rd || v.wr) || v.mis) begin
      chk("direct_valid", o_valid, 1'b1);
      chk("direct_mis", o_misaligned, v.mis);
      chk("direct_no_req", dmem_req, 1'b0);
      chk("direct_isvalid", o_struct.is_valid, !v.mis);
      chk("direct_rf", o_struct.rf_wr_data, v.rf);
      chk("direct_addr", o_struct.mem_addr, v.addr);
    end else begin
      for (int g = 0; g <= v.gd; g++) begin
        chk("req_hold", dmem_req, 1'b1);
        chk("we_hold", dmem_we, v.wr);
        chk("addr_hold", dmem_addr, {v.addr[63:3], 3'b000});
        chk("be_hold", dmem_be, v.be);
        chk("wdata_hold", dmem_wdata, v.wdata);
        chk("no_valid_in_req", o_valid, 1'b0);
        if (g == v.gd) dmem_gnt = 1'b1;
        step();
      end
      dmem_gnt = 1'b0;
      chk("req_drop", dmem_req, 1'b0);
      if (v.wr) begin
        chk("st_valid", o_valid, 1'b1);
        chk("st_rf", o_struct.rf_wr_data, v.rf);
        chk("st_data", o_struct.mem_data, v.data);
      end else begin
        chk("ld_wait_novalid", o_valid, 1'b0);
        chk("ld_wait_ready", o_ready, 1'b0);
        for (int r = 0; r < rvd; r++) step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = v.rdata;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = {$urandom, $urandom};
        chk("ld_valid", o_valid, 1'b1);
        chk("ld_mis", o_misaligned, 1'b0);
        chk("ld_isvalid", o_struct.is_valid, 1'b1);
        chk("ld_rf", o_struct.rf_wr_data, v.rf);
      end
    end
  endtask

  task automatic reset_during(input int stage);
    interconnection_struct s;
    s = '0;
    s.is_valid = 1'b1; s.mem_rd = 1'b1; s.mem_size = 2'd3; s.mem_addr = 64'hB000;
    in_s = s;
    step();
    in_s = '0;
    chk("rst_pre_req", dmem_req, 1'b1);
    if (stage == 1) begin
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      chk("rst_in_waitr_ready", o_ready, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", dmem_req, 1'b0);
    chk("rst_async_valid", o_valid, 1'b0);
    chk("rst_async_ready", o_ready, 1'b1);
    #1 rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = '1;
    step();
    dmem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_rvalid_ignored", o_valid, 1'b0);
      step();
    end
  endtask

  vec_t tbl[12];
  vec_t v;
  interconnection_struct s;
  int kind;

  initial begin
    tbl[0]  = mk(0,0,2'd0,0,64'h10,  64'h55,       64'h1234,64'h0,                 0, 0,8'h00,64'h0,                64'h1234);
    tbl[1]  = mk(1,0,2'd0,0,64'h1003,64'h0,        64'h0,   64'h00000000_80000000, 2, 0,8'h08,64'h0,                64'hFFFFFFFF_FFFFFF80);
    tbl[2]  = mk(1,0,2'd0,1,64'h1003,64'h0,        64'h0,   64'h00000000_80000000, 1, 0,8'h08,64'h0,                64'h80);
    tbl[3]  = mk(0,1,2'd1,0,64'h2006,64'hBEEF,     64'h77,  64'h0,                 3, 0,8'hC0,64'hBEEFBEEF_BEEFBEEF,64'h77);
    tbl[4]  = mk(1,0,2'd2,0,64'h3002,64'h0,        64'h99,  64'h0,                 0, 1,8'h00,64'h0,                64'h99);
    tbl[5]  = mk(1,0,2'd3,0,64'h4008,64'h0,        64'h0,   64'h87654321_12345678, 0, 0,8'hFF,64'h0,                64'h87654321_12345678);
    tbl[6]  = mk(1,0,2'd2,0,64'h5004,64'h0,        64'h0,   64'h80000001_00000000, 1, 0,8'hF0,64'h0,                64'hFFFFFFFF_80000001);
    tbl[7]  = mk(1,0,2'd1,1,64'h6002,64'h0,        64'h0,   64'h00000000_F00D0000, 2, 0,8'h0C,64'h0,                64'hF00D);
    tbl[8]  = mk(0,1,2'd0,0,64'h7005,64'h12AB,     64'h5,   64'h0,                 0, 0,8'h20,64'hABABABAB_ABABABAB,64'h5);
    tbl[9]  = mk(0,1,2'd3,0,64'h8004,64'h1,        64'h6,   64'h0,                 0, 1,8'h00,64'h0,                64'h6);
    tbl[10] = mk(0,1,2'd2,0,64'h9004,64'hDEADBEEF, 64'h7,   64'h0,                 1, 0,8'hF0,64'hDEADBEEF_DEADBEEF,64'h7);
    tbl[11] = mk(1,0,2'd1,0,64'hA006,64'h0,        64'h0,   64'h80010000_00000000, 0, 0,8'hC0,64'h0,                64'hFFFFFFFF_FFFF8001);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_mis", o_misaligned, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_be", dmem_be, 8'h00);
    chk("rst_addr", dmem_addr, 64'h0);
    chk("rst_struct_rf", o_struct.rf_wr_data, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_txn(tbl[i], i % 3);
    step();

    // backpressure: held output, then accept in the cycle wb_ready rises
    i_wb_ready = 1'b0;
    s = '0; s.is_valid = 1'b1; s.rf_wr_data = 64'hAAAA;
    in_s = s;
    step();
    in_s = '0;
    chk("bp_valid", o_valid, 1'b1);
    chk("bp_ready_low", o_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_hold_valid", o_valid, 1'b1);
      chk("bp_hold_rf", o_struct.rf_wr_data, 64'hAAAA);
      chk("bp_hold_ready", o_ready, 1'b0);
    end
    s.rf_wr_data = 64'hBBBB;
    in_s = s;
    i_wb_ready = 1'b1;
    #1;
    chk("bp_ready_rise", o_ready, 1'b1);
    step();
    in_s = '0;
    chk("bp_new_valid", o_valid, 1'b1);
    chk("bp_new_rf", o_struct.rf_wr_data, 64'hBBBB);

    // reset while a result is held
    i_wb_ready = 1'b0;
    step();
    chk("bp2_held", o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_held_valid", o_valid, 1'b0);
    chk("rst_held_rf", o_struct.rf_wr_data, 64'h0);
    #1 rst_n = 1'b1;
    i_wb_ready = 1'b1;
    step();

    reset_during(0);
    reset_during(1);

    // randomized transactions against the model
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      v.rd = (kind == 1); v.wr = (kind == 2);
      v.size = 2'($urandom); v.uns = 1'($urandom);
      v.addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) v.addr = v.addr & ~((64'd1 << v.size) - 64'd1);
      v.data = {$urandom, $urandom}; v.rf_in = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom}; v.gd = $urandom_range(0, 3);
      v.mis = (v.rd || v.wr) && m_mis(v.size, v.addr);
      v.be = m_be(v.size, v.addr);
      v.wdata = m_wdata(v.size, v.data);
      v.rf = (v.rd && !v.mis) ? m_load(v.size, v.uns, v.addr, v.rdata) : v.rf_in;
      run_txn(v, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
